t10_lcd_receiver: RTL and testbench

//  Receiving end of the team's HD44780-style 8-bit parallel LCD bus. Samples lcd_en/rs/rw/data

---
 rtl/t10_lcd_pkg.sv | 57 +++++
 rtl/t10_lcd_edge_sync.sv | 69 ++++++
 rtl/t10_lcd_receiver.sv | 152 +++++++++++++++
 tb/tb_t10_lcd_receiver.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t10_lcd_pkg.sv
// Shared definitions for the HD44780-style LCD receiver.
// Holds the command opcode masks, the DDRAM address landmarks, the receiver FSM
// state type and the helper functions for cursor arithmetic and shadow indexing.
package t10_lcd_pkg;

   // A command is classified by its highest set bit, so each mask is one bit.
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
   localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
   localparam logic [7:0] CMD_FUNC_SET  = 8'h20;
   localparam logic [7:0] CMD_SHIFT     = 8'h10;
   localparam logic [7:0] CMD_DISPLAY   = 8'h08;
   localparam logic [7:0] CMD_ENTRY     = 8'h04;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_CLEAR     = 8'h01;

   // DDRAM address landmarks of the two 40-character lines.
   localparam logic [6:0] ROW1_BASE  = 7'h00;
   localparam logic [6:0] ROW2_BASE  = 7'h40;
   localparam logic [6:0] LINE_END   = 7'h27;
   localparam logic [6:0] ROW2_END   = 7'h67;
   localparam logic [6:0] FRAME_LAST = 7'h4F;

   localparam int CELLS = 32;

   typedef enum logic {IDLE, CLEAR} lcd_state_t;

   // One cursor step inside the two-line address space, wrapping line to line.
   function automatic logic [6:0] cursor_step(input logic [6:0] addr, input logic inc);
      logic [6:0] r;
      if (inc) begin
         if (addr == LINE_END)      r = ROW2_BASE;
         else if (addr == ROW2_END) r = ROW1_BASE;
         else                       r = addr + 7'd1;
      end else begin
         if (addr == ROW2_BASE)      r = LINE_END;
         else if (addr == ROW1_BASE) r = ROW2_END;
         else                        r = addr - 7'd1;
      end
      return r;
   endfunction

   // Addresses that exist on a 2-line display.
   function automatic logic addr_valid(input logic [6:0] addr);
      return (addr <= LINE_END) || ((addr >= ROW2_BASE) && (addr <= ROW2_END));
   endfunction

   // Columns 0..15 of either line: bits [5:4] are zero for 0x00-0x0F and 0x40-0x4F.
   function automatic logic addr_visible(input logic [6:0] addr);
      return addr[5:4] == 2'b00;
   endfunction

   // Shadow cell index: line select in the MSB, column below it.
   function automatic logic [4:0] cell_index(input logic [6:0] addr);
      return {addr[6], addr[3:0]};
   endfunction

endpackage

// File: rtl/t10_lcd_edge_sync.sv
// Input conditioning for the LCD bus.
// Synchronises en/rs/rw/data through the same number of flops so they stay
// aligned, counts synchronised E-high clocks, and classifies each falling edge
// of E as a valid transfer (fall) or a too-short glitch (glitch).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   lcd_en/lcd_rs/lcd_rw/lcd_data  raw bus inputs
//   fall                        1-cycle: E fell after at least MIN_EN_HIGH high clocks
//   glitch                      1-cycle: E fell after fewer than MIN_EN_HIGH high clocks
//   rs, rw, data                synchronised bus fields, valid in the fall cycle
module t10_lcd_edge_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_EN_HIGH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_en,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   output logic       fall,
   output logic       glitch,
   output logic       rs,
   output logic       rw,
   output logic [7:0] data
);

   localparam int CW = $clog2(MIN_EN_HIGH + 1);

   logic [10:0]   sync_q [SYNC_STAGES];
   logic          en_s;
   logic          en_prev;
   logic [CW-1:0] high_cnt;
   logic          en_fell;

   // All bus fields share one synchroniser chain so the bits seen alongside the
   // E edge are the ones the controller drove with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign en_s = sync_q[SYNC_STAGES-1][10];
   assign rs   = sync_q[SYNC_STAGES-1][9];
   assign rw   = sync_q[SYNC_STAGES-1][8];
   assign data = sync_q[SYNC_STAGES-1][7:0];

   // The counter still holds the full high length in the cycle E is first seen
   // low, which is when the edge is judged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_prev  <= 1'b0;
         high_cnt <= '0;
      end else begin
         en_prev <= en_s;
         if (!en_s)                             high_cnt <= '0;
         else if (high_cnt < CW'(MIN_EN_HIGH))  high_cnt <= high_cnt + CW'(1);
      end
   end

   assign en_fell = en_prev && !en_s;
   assign fall    = en_fell && (high_cnt >= CW'(MIN_EN_HIGH));
   assign glitch  = en_fell && (high_cnt <  CW'(MIN_EN_HIGH));

endmodule

// File: rtl/t10_lcd_receiver.sv
// Receiving end of the 8-bit HD44780-style LCD bus.
// Decodes commands and data writes, maintains the cursor, and keeps a 2x16
// shadow of the visible DDRAM. A clear command runs a 32-clock fill sequencer.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   lcd_en/rw/rs/data  LCD bus from the controller
//   row_1, row_2    visible lines, column 0 in the top byte
//   disp_on         display-control D bit
//   entry_inc       entry-mode I/D bit
//   cursor_addr     current DDRAM address
//   wr_strobe       pulse per accepted transfer
//   frame_done      pulse when a data write lands at 0x4F
//   proto_err       pulse on glitch, read request, invalid address or dropped transfer
module t10_lcd_receiver
   import t10_lcd_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter int         MIN_EN_HIGH = 4,
   parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         lcd_en,
   input  logic         lcd_rw,
   input  logic         lcd_rs,
   input  logic [7:0]   lcd_data,
   output logic [127:0] row_1,
   output logic [127:0] row_2,
   output logic         disp_on,
   output logic         entry_inc,
   output logic [6:0]   cursor_addr,
   output logic         wr_strobe,
   output logic         frame_done,
   output logic         proto_err
);

   logic       fall;
   logic       glitch;
   logic       rs_s;
   logic       rw_s;
   logic [7:0] data_s;

   lcd_state_t state;
   lcd_state_t next_state;
   logic [4:0] clr_idx;
   logic [7:0] mem [CELLS];

   t10_lcd_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .MIN_EN_HIGH(MIN_EN_HIGH)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .lcd_en  (lcd_en),
      .lcd_rs  (lcd_rs),
      .lcd_rw  (lcd_rw),
      .lcd_data(lcd_data),
      .fall    (fall),
      .glitch  (glitch),
      .rs      (rs_s),
      .rw      (rw_s),
      .data    (data_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Only a clean clear command leaves IDLE; CLEAR lasts exactly one pass over the shadow.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (fall && !rw_s && !rs_s && (data_s == CMD_CLEAR)) next_state = CLEAR;
         CLEAR: if (clr_idx == 5'd31) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: shadow, cursor, mode bits and pulses. While clearing, every E edge
   // is reported and dropped. Command decode gives priority to the highest set
   // bit; CGRAM address, function set and a clear (handled by the FSM) change
   // nothing here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CELLS; i++) mem[i] <= CLEAR_CHAR;
         disp_on     <= 1'b0;
         entry_inc   <= 1'b1;
         cursor_addr <= ROW1_BASE;
         clr_idx     <= '0;
         wr_strobe   <= 1'b0;
         frame_done  <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         wr_strobe  <= 1'b0;
         frame_done <= 1'b0;
         proto_err  <= 1'b0;
         if (state == CLEAR) begin
            mem[clr_idx] <= CLEAR_CHAR;
            clr_idx      <= clr_idx + 5'd1;
            if (clr_idx == 5'd31) begin
               cursor_addr <= ROW1_BASE;
               entry_inc   <= 1'b1;
            end
            if (fall || glitch) proto_err <= 1'b1;
         end else if (glitch) begin
            proto_err <= 1'b1;
         end else if (fall) begin
            if (rw_s) begin
               proto_err <= 1'b1;
            end else begin
               wr_strobe <= 1'b1;
               if (rs_s) begin
                  if (addr_visible(cursor_addr)) mem[cell_index(cursor_addr)] <= data_s;
                  if (cursor_addr == FRAME_LAST) frame_done <= 1'b1;
                  cursor_addr <= cursor_step(cursor_addr, entry_inc);
               end else if ((data_s & CMD_SET_DDRAM) != 8'h00) begin
                  if (addr_valid(data_s[6:0])) begin
                     cursor_addr <= data_s[6:0];
                  end else begin
                     cursor_addr <= ROW1_BASE;
                     proto_err   <= 1'b1;
                  end
               end else if ((data_s & (CMD_SET_CGRAM | CMD_FUNC_SET)) != 8'h00) begin
               end else if ((data_s & CMD_SHIFT) != 8'h00) begin
                  if (!data_s[3]) cursor_addr <= cursor_step(cursor_addr, data_s[2]);
               end else if ((data_s & CMD_DISPLAY) != 8'h00) begin
                  disp_on <= data_s[2];
               end else if ((data_s & CMD_ENTRY) != 8'h00) begin
                  entry_inc <= data_s[1];
               end else if ((data_s & CMD_HOME) != 8'h00) begin
                  cursor_addr <= ROW1_BASE;
               end else if ((data_s & CMD_CLEAR) != 8'h00) begin
                  clr_idx <= '0;
               end
            end
         end
      end
   end

   // Pack the shadow so column 0 sits in the most significant byte.
   always_comb begin
      row_1 = '0;
      row_2 = '0;
      for (int c = 0; c < 16; c++) begin
         row_1[127 - 8*c -: 8] = mem[c];
         row_2[127 - 8*c -: 8] = mem[16 + c];
      end
   end

endmodule

// File: tb/tb_t10_lcd_receiver.sv
// Self-checking bench for t10_lcd_receiver.
// Drives controller-style bus transfers and compares the receiver against a
// behavioural model that treats DDRAM as a linear 80-position ring.
module tb_t10_lcd_receiver;

   localparam int         MIN_EN_HIGH = 4;
   localparam logic [7:0] CLEAR_CHAR  = 8'h20;

   logic         clk = 1'b0;
   logic         rst;
   logic         lcd_en;
   logic         lcd_rw;
   logic         lcd_rs;
   logic [7:0]   lcd_data;
   logic [127:0] row_1;
   logic [127:0] row_2;
   logic         disp_on;
   logic         entry_inc;
   logic [6:0]   cursor_addr;
   logic         wr_strobe;
   logic         frame_done;
   logic         proto_err;

   int checks   = 0;
   int failures = 0;
   int wr_cnt   = 0;
   int fd_cnt   = 0;
   int pe_cnt   = 0;

   logic [7:0] m_cell [2][16];
   int         m_cursor;
   bit         m_inc;
   bit         m_disp;
   bit         m_clearing;
   int         m_wr = 0;
   int         m_fd = 0;
   int         m_pe = 0;

   logic [127:0] blank_row;

   t10_lcd_receiver #(
      .SYNC_STAGES(2),
      .MIN_EN_HIGH(MIN_EN_HIGH),
      .CLEAR_CHAR (CLEAR_CHAR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .lcd_en     (lcd_en),
      .lcd_rw     (lcd_rw),
      .lcd_rs     (lcd_rs),
      .lcd_data   (lcd_data),
      .row_1      (row_1),
      .row_2      (row_2),
      .disp_on    (disp_on),
      .entry_inc  (entry_inc),
      .cursor_addr(cursor_addr),
      .wr_strobe  (wr_strobe),
      .frame_done (frame_done),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (wr_strobe)  wr_cnt++;
      if (frame_done) fd_cnt++;
      if (proto_err)  pe_cnt++;
   end

   // Model: addresses 0x00-0x27 are ring positions 0-39, 0x40-0x67 are 40-79.
   function automatic int lin_of(input int a);
      return (a < 64) ? a : a - 64 + 40;
   endfunction

   function automatic int addr_of(input int l);
      return (l < 40) ? l : l - 40 + 64;
   endfunction

   function automatic logic [127:0] exp_row(input int r);
      logic [127:0] v;
      v = '0;
      for (int c = 0; c < 16; c++) v[127 - 8*c -: 8] = m_cell[r][c];
      return v;
   endfunction

   task automatic model_step(input bit inc);
      int l;
      l = lin_of(m_cursor);
      l = inc ? (l + 1) % 80 : (l + 79) % 80;
      m_cursor = addr_of(l);
   endtask

   task automatic model_reset();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 16; c++) m_cell[r][c] = CLEAR_CHAR;
      m_cursor   = 0;
      m_inc      = 1'b1;
      m_disp     = 1'b0;
      m_clearing = 1'b0;
   endtask

   task automatic model_xfer(input bit rs, input bit rw, input int d);
      int a;
      if (m_clearing || rw) begin
         m_pe++;
      end else begin
         m_wr++;
         if (rs) begin
            if (m_cursor < 16) m_cell[0][m_cursor] = 8'(d);
            else if (m_cursor >= 64 && m_cursor < 80) m_cell[1][m_cursor - 64] = 8'(d);
            if (m_cursor == 79) m_fd++;
            model_step(m_inc);
         end else if (d >= 128) begin
            a = d - 128;
            if (a <= 39 || (a >= 64 && a <= 103)) m_cursor = a;
            else begin
               m_cursor = 0;
               m_pe++;
            end
         end else if (d >= 32) begin
            m_cursor = m_cursor;
         end else if (d >= 16) begin
            if ((d & 8) == 0) model_step((d & 4) != 0);
         end else if (d >= 8) begin
            m_disp = (d & 4) != 0;
         end else if (d >= 4) begin
            m_inc = (d & 2) != 0;
         end else if (d >= 2) begin
            m_cursor = 0;
         end else if (d == 1) begin
            for (int r = 0; r < 2; r++)
               for (int c = 0; c < 16; c++) m_cell[r][c] = CLEAR_CHAR;
            m_cursor   = 0;
            m_inc      = 1'b1;
            m_clearing = 1'b1;
         end
      end
   endtask

   // One E pulse of 'high' clocks, bus held for 'tail' clocks after E falls.
   task automatic send(input bit rs, input bit rw, input logic [7:0] d, input int high, input int tail);
      @(posedge clk); #1;
      lcd_rs   = rs;
      lcd_rw   = rw;
      lcd_data = d;
      lcd_en   = 1'b1;
      repeat (high) @(posedge clk);
      #1 lcd_en = 1'b0;
      repeat (tail) @(posedge clk);
      #1;
      if (high >= MIN_EN_HIGH) model_xfer(rs, rw, int'(d));
      else m_pe++;
   endtask

   task automatic wait_clear();
      repeat (40) @(posedge clk);
      #1 m_clearing = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; lcd_en = 1'b0; lcd_rw = 1'b0; lcd_rs = 1'b0; lcd_data = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      checks++; if (row_1 !== blank_row) begin failures++; $display("[TB] FAIL reset_row_1 got=%h exp=%h", row_1, blank_row); end
      checks++; if (row_2 !== blank_row) begin failures++; $display("[TB] FAIL reset_row_2 got=%h exp=%h", row_2, blank_row); end
      checks++; if ({disp_on, entry_inc, cursor_addr} !== {1'b0, 1'b1, 7'h00}) begin failures++; $display("[TB] FAIL reset_ctrl got=%b/%b/%h exp=0/1/00", disp_on, entry_inc, cursor_addr); end
      checks++; if ({wr_strobe, frame_done, proto_err} !== 3'b000) begin failures++; $display("[TB] FAIL reset_pulses got=%b exp=000", {wr_strobe, frame_done, proto_err}); end
   endtask

   task automatic test_init();
      send(1'b0, 1'b0, 8'h38, 4, 6);
      send(1'b0, 1'b0, 8'h08, 4, 6);
      send(1'b0, 1'b0, 8'h01, 4, 6);
      wait_clear();
      send(1'b0, 1'b0, 8'h06, 4, 6);
      send(1'b0, 1'b0, 8'h0C, 4, 6);
      checks++; if ({disp_on, entry_inc, cursor_addr} !== {1'b1, 1'b1, 7'h00}) begin failures++; $display("[TB] FAIL init_ctrl got=%b/%b/%h exp=1/1/00", disp_on, entry_inc, cursor_addr); end
      checks++; if (row_1 !== blank_row || row_2 !== blank_row) begin failures++; $display("[TB] FAIL init_rows got=%h %h", row_1, row_2); end
      checks++; if (wr_cnt !== 5) begin failures++; $display("[TB] FAIL init_wr_count got=%0d exp=5", wr_cnt); end
   endtask

   task automatic test_loopback();
      string s1;
      string s2;
      int    fd0;
      s1  = "HELLO WORLD 1234";
      s2  = "ABCDEFGHIJKLMNOP";
      fd0 = fd_cnt;
      for (int pass = 0; pass < 2; pass++) begin
         send(1'b0, 1'b0, 8'h80, 4, 6);
         for (int i = 0; i < 16; i++) send(1'b1, 1'b0, s1[i], 4, 6);
         send(1'b0, 1'b0, 8'hC0, 4, 6);
         for (int i = 0; i < 16; i++) send(1'b1, 1'b0, s2[i], 4, 6);
      end
      checks++; if (row_1 !== 128'("HELLO WORLD 1234")) begin failures++; $display("[TB] FAIL loop_row_1 got=%h exp=%h", row_1, 128'("HELLO WORLD 1234")); end
      checks++; if (row_2 !== 128'("ABCDEFGHIJKLMNOP")) begin failures++; $display("[TB] FAIL loop_row_2 got=%h exp=%h", row_2, 128'("ABCDEFGHIJKLMNOP")); end
      checks++; if (fd_cnt - fd0 !== 2) begin failures++; $display("[TB] FAIL loop_frame_done got=%0d exp=2", fd_cnt - fd0); end
      checks++; if (cursor_addr !== 7'h50) begin failures++; $display("[TB] FAIL loop_cursor got=%h exp=50", cursor_addr); end
   endtask

   task automatic test_addressing();
      int pe0;
      send(1'b0, 1'b0, 8'h8F, 4, 6);
      send(1'b1, 1'b0, "X", 4, 6);
      send(1'b1, 1'b0, "Y", 4, 6);
      checks++; if (row_1[7:0] !== "X") begin failures++; $display("[TB] FAIL addr_x got=%h exp=58", row_1[7:0]); end
      checks++; if (cursor_addr !== 7'h11) begin failures++; $display("[TB] FAIL addr_invisible got=%h exp=11", cursor_addr); end
      checks++; if (row_1 !== exp_row(0) || row_2 !== exp_row(1)) begin failures++; $display("[TB] FAIL addr_rows got=%h %h", row_1, row_2); end
      send(1'b0, 1'b0, 8'h04, 4, 6);
      send(1'b0, 1'b0, 8'h80, 4, 6);
      send(1'b1, 1'b0, "Z", 4, 6);
      checks++; if (cursor_addr !== 7'h67 || row_1[127:120] !== "Z") begin failures++; $display("[TB] FAIL addr_dec_wrap got=%h/%h exp=67/5a", cursor_addr, row_1[127:120]); end
      send(1'b0, 1'b0, 8'h06, 4, 6);
      send(1'b0, 1'b0, 8'hA7, 4, 6);
      send(1'b1, 1'b0, "Q", 4, 6);
      checks++; if (cursor_addr !== 7'h40) begin failures++; $display("[TB] FAIL addr_inc_wrap got=%h exp=40", cursor_addr); end
      pe0 = pe_cnt;
      send(1'b0, 1'b0, 8'hE8, 4, 6);
      checks++; if (cursor_addr !== 7'h00 || pe_cnt - pe0 !== 1) begin failures++; $display("[TB] FAIL addr_invalid got=%h/%0d exp=00/1", cursor_addr, pe_cnt - pe0); end
   endtask

   task automatic test_glitch();
      int pe0;
      int wr0;
      pe0 = pe_cnt; wr0 = wr_cnt;
      send(1'b1, 1'b0, "G", 2, 6);
      checks++; if (pe_cnt - pe0 !== 1 || wr_cnt !== wr0) begin failures++; $display("[TB] FAIL glitch_2 got=pe%0d/wr%0d exp=1/0", pe_cnt - pe0, wr_cnt - wr0); end
      send(1'b1, 1'b0, "H", 3, 6);
      checks++; if (row_1 !== exp_row(0) || cursor_addr !== 7'(m_cursor)) begin failures++; $display("[TB] FAIL glitch_nochange got=%h/%h", row_1, cursor_addr); end
      send(1'b1, 1'b0, "V", 4, 6);
      checks++; if (row_1[127:120] !== "V" || wr_cnt - wr0 !== 1) begin failures++; $display("[TB] FAIL glitch_min_len got=%h/%0d exp=56/1", row_1[127:120], wr_cnt - wr0); end
      pe0 = pe_cnt;
      send(1'b1, 1'b1, "R", 4, 6);
      checks++; if (pe_cnt - pe0 !== 1 || row_1 !== exp_row(0)) begin failures++; $display("[TB] FAIL read_req got=%0d exp=1", pe_cnt - pe0); end
      pe0 = pe_cnt;
      send(1'b0, 1'b0, 8'h01, 4, 3);
      send(1'b1, 1'b0, "W", 4, 6);
      wait_clear();
      checks++; if (pe_cnt - pe0 !== 1) begin failures++; $display("[TB] FAIL clear_drop_err got=%0d exp=1", pe_cnt - pe0); end
      checks++; if (row_1 !== blank_row || row_2 !== blank_row || cursor_addr !== 7'h00) begin failures++; $display("[TB] FAIL clear_drop_rows got=%h %h %h", row_1, row_2, cursor_addr); end
   endtask

   task automatic test_reset_mid();
      send(1'b0, 1'b0, 8'h0C, 4, 6);
      send(1'b0, 1'b0, 8'hCF, 4, 6);
      send(1'b1, 1'b0, "B", 4, 6);
      send(1'b0, 1'b0, 8'h01, 4, 6);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++; if (row_2 !== blank_row || disp_on !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_clear got=%h/%b", row_2, disp_on); end
      checks++; if (cursor_addr !== 7'h00 || entry_inc !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_clear_ctrl got=%h/%b exp=00/1", cursor_addr, entry_inc); end
      @(negedge clk) rst = 1'b0;
      model_reset();
      send(1'b1, 1'b0, "M", 4, 6);
      send(1'b1, 1'b0, "N", 4, 6);
      @(posedge clk); #1;
      lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = "K"; lcd_en = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++; if (row_1 !== blank_row || cursor_addr !== 7'h00) begin failures++; $display("[TB] FAIL rst_mid_pulse got=%h/%h", row_1, cursor_addr); end
      repeat (3) @(posedge clk);
      #1 lcd_en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      model_reset();
      send(1'b1, 1'b0, "R", 4, 6);
      checks++; if (row_1[127:120] !== "R" || cursor_addr !== 7'h01) begin failures++; $display("[TB] FAIL rst_next_xfer got=%h/%h exp=52/01", row_1[127:120], cursor_addr); end
   endtask

   task automatic test_random();
      int         k;
      bit         rs;
      bit         rw;
      int         high;
      logic [7:0] d;
      for (int i = 0; i < 80; i++) begin
         k    = int'($urandom_range(0, 12));
         rs   = 1'b0;
         rw   = 1'b0;
         high = int'($urandom_range(4, 6));
         d    = 8'h00;
         case (k)
            0, 1, 2, 3: begin rs = 1'b1; d = 8'($urandom_range(8'h21, 8'h7E)); end
            4: begin
               if ($urandom_range(0, 1) == 1) d = {1'b1, 1'($urandom_range(0, 1)), 2'b00, 4'($urandom_range(0, 15))};
               else d = 8'h80 | 8'($urandom_range(0, 127));
            end
            5: d = 8'h10 | 8'($urandom_range(0, 15));
            6: d = 8'h08 | 8'($urandom_range(0, 7));
            7: d = 8'h04 | 8'($urandom_range(0, 3));
            8: d = 8'h02 | 8'($urandom_range(0, 1));
            9: begin
               case ($urandom_range(0, 2))
                  0: d = 8'h40 | 8'($urandom_range(0, 63));
                  1: d = 8'h20 | 8'($urandom_range(0, 31));
                  default: d = 8'h00;
               endcase
            end
            10: begin rw = 1'b1; rs = 1'($urandom_range(0, 1)); d = 8'($urandom); end
            11: begin rs = 1'b1; d = 8'($urandom); high = int'($urandom_range(1, MIN_EN_HIGH - 1)); end
            default: d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h14;
         endcase
         send(rs, rw, d, high, 6);
         if (m_clearing) wait_clear();
         checks++; if (row_1 !== exp_row(0)) begin failures++; $display("[TB] FAIL rand_row_1 i=%0d got=%h exp=%h", i, row_1, exp_row(0)); end
         checks++; if (row_2 !== exp_row(1)) begin failures++; $display("[TB] FAIL rand_row_2 i=%0d got=%h exp=%h", i, row_2, exp_row(1)); end
         checks++; if (cursor_addr !== 7'(m_cursor)) begin failures++; $display("[TB] FAIL rand_cursor i=%0d d=%h got=%h exp=%h", i, d, cursor_addr, 7'(m_cursor)); end
         checks++; if (disp_on !== m_disp || entry_inc !== m_inc) begin failures++; $display("[TB] FAIL rand_mode i=%0d got=%b/%b exp=%b/%b", i, disp_on, entry_inc, m_disp, m_inc); end
      end
   endtask

   task automatic test_counts();
      checks++; if (wr_cnt !== m_wr) begin failures++; $display("[TB] FAIL count_wr got=%0d exp=%0d", wr_cnt, m_wr); end
      checks++; if (fd_cnt !== m_fd) begin failures++; $display("[TB] FAIL count_frame got=%0d exp=%0d", fd_cnt, m_fd); end
      checks++; if (pe_cnt !== m_pe) begin failures++; $display("[TB] FAIL count_err got=%0d exp=%0d", pe_cnt, m_pe); end
   endtask

   // Scenarios run in sequence; counts are cross-checked after the directed and random phases.
   initial begin
      blank_row = {16{CLEAR_CHAR}};
      test_reset();
      test_init();
      test_loopback();
      test_addressing();
      test_glitch();
      test_counts();
      test_reset_mid();
      test_random();
      test_counts();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
